decode_issue_latch: RTL and testbench

- Consumer end of the load-use stall protocol. Sits between the instruction-fetch/IMEM interface and the decode and post-decode pipeline.
- Owns the PC register and the decode latch. Holds both while a stall is requested.
- Injects bubbles into the first post-decode stage during a stall.
- Captures IMEM returns that are already in flight in a small skid buffer, so no instruction is lost or duplicated.

---
 rtl/decode_issue_latch_pkg.sv | 31 +++
 rtl/decode_issue_latch_skid_fifo.sv | 67 ++++++
 rtl/decode_issue_latch.sv | 185 ++++++++++++++++++
 tb/tb_decode_issue_latch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_latch_pkg.sv
// Shared types for the decode/issue latch slice.
//   miop_t        - micro-op opcode
//   miinst_t      - micro-instruction carried from IMEM through decode/issue
//   MIINST_BUBBLE - the canonical bubble (NOP, all other fields zero)
package decode_issue_latch_pkg;

    typedef enum logic [3:0] {
        MIOP_NOP = 4'd0,
        MIOP_L   = 4'd1,
        MIOP_S   = 4'd2,
        MIOP_ALU = 4'd3,
        MIOP_BR  = 4'd4
    } miop_t;

    typedef struct packed {
        miop_t       op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } miinst_t;

    localparam miinst_t MIINST_BUBBLE = '{
        op:  MIOP_NOP,
        rd:  5'd0,
        rs1: 5'd0,
        rs2: 5'd0,
        imm: 32'd0
    };

endpackage

// File: rtl/decode_issue_latch_skid_fifo.sv
// Small 1R1W FIFO that absorbs IMEM returns which land while decode is held.
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_flush       - drop all entries (redirect)
//   i_push/i_data - write one entry (ignored when full without a pop)
//   i_pop         - consume the head (ignored when empty)
//   o_data        - head entry, valid when !o_empty
//   o_empty       - no entries
//   o_count       - registered occupancy
module decode_issue_latch_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/decode_issue_latch.sv
// Consumer end of the load-use stall protocol: owns the fetch PC and the
// decode latch, holds both while a stall is requested, injects bubbles into
// post-decode stage 0, and parks in-flight IMEM returns in a skid FIFO.
// Ports:
//   i_clk, i_rst                 - clock, synchronous active-high reset
//   i_stall_pc, i_stall_phase    - stall request / echoed extended stall
//   i_redirect, i_redirect_pc    - branch/jump redirect from execute
//   o_imem_addr, o_imem_req      - fetch address and request
//   i_imem_miinst                - IMEM return, IMEM_LATENCY after its request
//   o_dec_miinst/_pc/_valid      - decode-stage instruction
//   o_iss_miinst/_valid          - instruction entering post-decode stage 0
module decode_issue_latch
    import decode_issue_latch_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int INST_BYTES   = 8,
    parameter int IMEM_LATENCY = 1,
    parameter int SKID_DEPTH   = 2   // must be >= IMEM_LATENCY + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall_pc,
    input  logic              i_stall_phase,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_req,
    input  miinst_t           i_imem_miinst,
    output miinst_t           o_dec_miinst,
    output logic [ADDR_W-1:0] o_dec_pc,
    output logic              o_dec_valid,
    output miinst_t           o_iss_miinst,
    output logic              o_iss_valid
);

    localparam int CNT_W  = $clog2(SKID_DEPTH + 1);
    localparam int CRED_W = $clog2(SKID_DEPTH + IMEM_LATENCY + 1);
    localparam int INST_W = $bits(miinst_t);
    localparam int ENT_W  = ADDR_W + INST_W;

    logic [ADDR_W-1:0]       r_pc;
    logic                    r_fetch_en;
    logic [IMEM_LATENCY-1:0] r_inf_valid;
    logic [IMEM_LATENCY-1:0] r_inf_drop;
    logic [ADDR_W-1:0]       r_inf_pc [IMEM_LATENCY];
    miinst_t                 r_dec_miinst;
    logic [ADDR_W-1:0]       r_dec_pc;
    logic                    r_dec_valid;
    miinst_t                 r_iss_miinst;
    logic                    r_iss_valid;

    logic              w_hold;
    logic              w_req;
    logic              w_ret_valid;
    logic [ADDR_W-1:0] w_fetch_pc;
    logic [CRED_W-1:0] w_inflight_count;
    logic [CRED_W-1:0] w_credit_used;
    logic              w_skid_push;
    logic              w_skid_pop;
    logic              w_skid_empty;
    logic [CNT_W-1:0]  w_skid_count;
    logic [ENT_W-1:0]  w_ret_entry;
    logic [ENT_W-1:0]  w_head_entry;

    assign w_hold = i_stall_pc | i_stall_phase;

    // A redirect fetches its target in the same cycle, so the address is
    // bypassed around the PC register for that one cycle.
    assign w_fetch_pc = i_redirect ? i_redirect_pc : r_pc;

    always_comb begin
        w_inflight_count = '0;
        for (int i = 0; i < IMEM_LATENCY; i++) begin
            if (r_inf_valid[i] && !r_inf_drop[i])
                w_inflight_count = w_inflight_count + CRED_W'(1);
        end
    end

    // Every live request already owns a slot in the skid, so a stall can
    // never overflow it. A redirect flushes skid and in-flight state, which
    // always leaves a credit free.
    assign w_credit_used = CRED_W'(w_skid_count) + w_inflight_count;
    assign w_req = r_fetch_en &
                   (i_redirect | (~w_hold & (w_credit_used < CRED_W'(SKID_DEPTH))));

    assign w_ret_valid = r_inf_valid[IMEM_LATENCY-1] & ~r_inf_drop[IMEM_LATENCY-1]
                         & ~i_redirect;
    assign w_ret_entry = {r_inf_pc[IMEM_LATENCY-1], i_imem_miinst};

    // Head is always consumed before a bypass; a return that cannot go
    // straight into decode queues behind the head.
    assign w_skid_pop  = ~i_redirect & ~w_hold & ~w_skid_empty;
    assign w_skid_push = w_ret_valid & (w_hold | ~w_skid_empty);

    decode_issue_latch_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .W     (ENT_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_redirect),
        .i_push  (w_skid_push),
        .i_data  (w_ret_entry),
        .i_pop   (w_skid_pop),
        .o_data  (w_head_entry),
        .o_empty (w_skid_empty),
        .o_count (w_skid_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= '0;
            r_fetch_en <= 1'b0;
        end else begin
            r_fetch_en <= 1'b1;
            r_pc       <= w_fetch_pc + (w_req ? ADDR_W'(INST_BYTES) : '0);
        end
    end

    // In-flight tags: slot 0 is the newest request, slot IMEM_LATENCY-1 is
    // the one whose data is on i_imem_miinst this cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inf_valid <= '0;
            r_inf_drop  <= '0;
        end else begin
            for (int i = IMEM_LATENCY - 1; i > 0; i--) begin
                r_inf_valid[i] <= r_inf_valid[i-1];
                r_inf_drop[i]  <= r_inf_drop[i-1] | i_redirect;
            end
            r_inf_valid[0] <= w_req;
            r_inf_drop[0]  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = IMEM_LATENCY - 1; i > 0; i--)
            r_inf_pc[i] <= r_inf_pc[i-1];
        r_inf_pc[0] <= w_fetch_pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dec_miinst <= MIINST_BUBBLE;
            r_dec_pc     <= '0;
            r_dec_valid  <= 1'b0;
            r_iss_miinst <= MIINST_BUBBLE;
            r_iss_valid  <= 1'b0;
        end else if (i_redirect) begin
            r_dec_miinst <= MIINST_BUBBLE;
            r_dec_valid  <= 1'b0;
            r_iss_miinst <= MIINST_BUBBLE;
            r_iss_valid  <= 1'b0;
        end else if (w_hold) begin
            r_iss_miinst <= MIINST_BUBBLE;
            r_iss_valid  <= 1'b0;
        end else begin
            // An invalid decode slot always carries the bubble, so iss
            // receives a clean NOP when dec_valid is low.
            r_iss_miinst <= r_dec_miinst;
            r_iss_valid  <= r_dec_valid;
            if (!w_skid_empty) begin
                r_dec_pc     <= w_head_entry[ENT_W-1 -: ADDR_W];
                r_dec_miinst <= miinst_t'(w_head_entry[INST_W-1:0]);
                r_dec_valid  <= 1'b1;
            end else if (w_ret_valid) begin
                r_dec_pc     <= w_ret_entry[ENT_W-1 -: ADDR_W];
                r_dec_miinst <= miinst_t'(w_ret_entry[INST_W-1:0]);
                r_dec_valid  <= 1'b1;
            end else begin
                r_dec_miinst <= MIINST_BUBBLE;
                r_dec_valid  <= 1'b0;
            end
        end
    end

    assign o_imem_addr  = w_fetch_pc;
    assign o_imem_req   = w_req;
    assign o_dec_miinst = r_dec_miinst;
    assign o_dec_pc     = r_dec_pc;
    assign o_dec_valid  = r_dec_valid;
    assign o_iss_miinst = r_iss_miinst;
    assign o_iss_valid  = r_iss_valid;

endmodule

// File: tb/tb_decode_issue_latch.sv
// Directed bench for decode_issue_latch. The IMEM model returns, one cycle
// after each address, an MIOP_L instruction whose imm is addr/8 and rd is
// addr[7:3], so every issued slot identifies its own PC.
module tb_decode_issue_latch;
    import decode_issue_latch_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall_pc;
    logic        i_stall_phase;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic [63:0] o_imem_addr;
    logic        o_imem_req;
    miinst_t     i_imem_miinst;
    miinst_t     o_dec_miinst;
    logic [63:0] o_dec_pc;
    logic        o_dec_valid;
    miinst_t     o_iss_miinst;
    logic        o_iss_valid;

    int checks   = 0;
    int failures = 0;

    decode_issue_latch u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall_pc    (i_stall_pc),
        .i_stall_phase (i_stall_phase),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_addr   (o_imem_addr),
        .o_imem_req    (o_imem_req),
        .i_imem_miinst (i_imem_miinst),
        .o_dec_miinst  (o_dec_miinst),
        .o_dec_pc      (o_dec_pc),
        .o_dec_valid   (o_dec_valid),
        .o_iss_miinst  (o_iss_miinst),
        .o_iss_valid   (o_iss_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic miinst_t mk(input logic [63:0] a);
        miinst_t m;
        m     = MIINST_BUBBLE;
        m.op  = MIOP_L;
        m.rd  = a[7:3];
        m.imm = a[34:3];
        return m;
    endfunction

    always @(posedge i_clk) i_imem_miinst <= mk(o_imem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic req, input logic [63:0] addr);
        chk({tag, "_req"}, 64'(o_imem_req), 64'(req));
        chk({tag, "_addr"}, o_imem_addr, addr);
    endtask

    task automatic chk_dec(input string tag, input logic v, input logic [63:0] pc);
        chk({tag, "_dec_valid"}, 64'(o_dec_valid), 64'(v));
        if (v) begin
            chk({tag, "_dec_pc"}, o_dec_pc, pc);
            chk({tag, "_dec_inst"}, 64'(o_dec_miinst), 64'(mk(pc)));
        end
    endtask

    task automatic chk_iss(input string tag, input logic v, input logic [63:0] pc);
        chk({tag, "_iss_valid"}, 64'(o_iss_valid), 64'(v));
        if (v) chk({tag, "_iss_inst"}, 64'(o_iss_miinst), 64'(mk(pc)));
        else   chk({tag, "_iss_bubble"}, 64'(o_iss_miinst), 64'(MIINST_BUBBLE));
    endtask

    task automatic chk_skid(input string tag, input int n);
        chk({tag, "_skid"}, 64'(u_dut.w_skid_count), 64'(n));
    endtask

    // Advance to just after the next rising edge; inputs are then driven
    // and outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst         = 1'b1;
        i_stall_pc    = 1'b0;
        i_stall_phase = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        cyc(); cyc();

        // C0: first cycle after reset
        i_rst = 1'b0; #1;
        chk_fetch("c0", 1'b0, 64'h0); chk_dec("c0", 1'b0, 64'h0); chk_iss("c0", 1'b0, 64'h0);
        chk("c0_dec_op", 64'(o_dec_miinst.op), 64'(MIOP_NOP));
        chk_skid("c0", 0);
        cyc(); #1;  // C1
        chk_fetch("c1", 1'b1, 64'h0); chk_dec("c1", 1'b0, 64'h0); chk_iss("c1", 1'b0, 64'h0);
        cyc(); #1;  // C2
        chk_fetch("c2", 1'b1, 64'h8); chk_dec("c2", 1'b0, 64'h0); chk_iss("c2", 1'b0, 64'h0);
        cyc(); #1;  // C3
        chk_fetch("c3", 1'b1, 64'h10); chk_dec("c3", 1'b1, 64'h0); chk_iss("c3", 1'b0, 64'h0);
        cyc(); #1;  // C4
        chk_fetch("c4", 1'b1, 64'h18); chk_dec("c4", 1'b1, 64'h8); chk_iss("c4", 1'b1, 64'h0);
        cyc(); #1;  // C5
        chk_fetch("c5", 1'b1, 64'h20); chk_dec("c5", 1'b1, 64'h10); chk_iss("c5", 1'b1, 64'h8);

        // Single stall pulse while dec_pc = 0x18
        cyc(); i_stall_pc = 1'b1; #1;  // C6
        chk_fetch("c6", 1'b0, 64'h28); chk_dec("c6", 1'b1, 64'h18); chk_iss("c6", 1'b1, 64'h10);
        cyc(); i_stall_pc = 1'b0; #1;  // C7
        chk_fetch("c7", 1'b1, 64'h28); chk_dec("c7", 1'b1, 64'h18); chk_iss("c7", 1'b0, 64'h0);
        chk_skid("c7", 1);
        cyc(); #1;  // C8
        chk_fetch("c8", 1'b1, 64'h30); chk_dec("c8", 1'b1, 64'h20); chk_iss("c8", 1'b1, 64'h18);
        chk_skid("c8", 0);
        cyc(); #1;  // C9
        chk_fetch("c9", 1'b1, 64'h38); chk_dec("c9", 1'b1, 64'h28); chk_iss("c9", 1'b1, 64'h20);

        // stall_pc then stall_phase for 3 cycles
        cyc(); i_stall_pc = 1'b1; #1;  // C10
        chk_fetch("c10", 1'b0, 64'h40); chk_dec("c10", 1'b1, 64'h30); chk_iss("c10", 1'b1, 64'h28);
        for (int k = 11; k <= 13; k++) begin
            cyc(); i_stall_pc = 1'b0; i_stall_phase = 1'b1; #1;
            chk_fetch($sformatf("c%0d", k), 1'b0, 64'h40);
            chk_dec($sformatf("c%0d", k), 1'b1, 64'h30);
            chk_iss($sformatf("c%0d", k), 1'b0, 64'h0);
            chk_skid($sformatf("c%0d", k), 1);
        end
        cyc(); i_stall_phase = 1'b0; #1;  // C14
        chk_fetch("c14", 1'b1, 64'h40); chk_dec("c14", 1'b1, 64'h30); chk_iss("c14", 1'b0, 64'h0);
        cyc(); #1;  // C15
        chk_fetch("c15", 1'b1, 64'h48); chk_dec("c15", 1'b1, 64'h38); chk_iss("c15", 1'b1, 64'h30);
        chk_skid("c15", 0);
        cyc(); #1;  // C16
        chk_fetch("c16", 1'b1, 64'h50); chk_dec("c16", 1'b1, 64'h40); chk_iss("c16", 1'b1, 64'h38);

        // Stall parks 0x50 in the skid, then redirect + stall_pc together
        cyc(); i_stall_pc = 1'b1; #1;  // C17
        chk_fetch("c17", 1'b0, 64'h58); chk_dec("c17", 1'b1, 64'h48); chk_iss("c17", 1'b1, 64'h40);
        cyc(); i_redirect = 1'b1; i_redirect_pc = 64'h1000; #1;  // C18
        chk_skid("c18", 1);
        chk_fetch("c18", 1'b1, 64'h1000); chk_dec("c18", 1'b1, 64'h48); chk_iss("c18", 1'b0, 64'h0);
        cyc(); i_redirect = 1'b0; i_stall_pc = 1'b0; i_stall_phase = 1'b1; #1;  // C19
        chk_fetch("c19", 1'b0, 64'h1008); chk_dec("c19", 1'b0, 64'h0); chk_iss("c19", 1'b0, 64'h0);
        chk_skid("c19", 0);
        cyc(); i_stall_phase = 1'b0; #1;  // C20
        chk_fetch("c20", 1'b1, 64'h1008); chk_dec("c20", 1'b0, 64'h0); chk_iss("c20", 1'b0, 64'h0);
        chk_skid("c20", 1);
        cyc(); #1;  // C21
        chk_fetch("c21", 1'b1, 64'h1010); chk_dec("c21", 1'b1, 64'h1000); chk_iss("c21", 1'b0, 64'h0);
        cyc(); #1;  // C22
        chk_fetch("c22", 1'b1, 64'h1018); chk_dec("c22", 1'b1, 64'h1008); chk_iss("c22", 1'b1, 64'h1000);

        // Redirect while 0x1018 is in flight
        cyc(); i_redirect = 1'b1; i_redirect_pc = 64'h2000; #1;  // C23
        chk_fetch("c23", 1'b1, 64'h2000); chk_dec("c23", 1'b1, 64'h1010); chk_iss("c23", 1'b1, 64'h1008);
        cyc(); i_redirect = 1'b0; #1;  // C24
        chk_fetch("c24", 1'b1, 64'h2008); chk_dec("c24", 1'b0, 64'h0); chk_iss("c24", 1'b0, 64'h0);
        chk_skid("c24", 0);
        cyc(); #1;  // C25
        chk_fetch("c25", 1'b1, 64'h2010); chk_dec("c25", 1'b1, 64'h2000); chk_iss("c25", 1'b0, 64'h0);

        // Reset during a 2-cycle stall with an occupied skid
        cyc(); i_stall_pc = 1'b1; #1;  // C26
        chk_fetch("c26", 1'b0, 64'h2018); chk_dec("c26", 1'b1, 64'h2008); chk_iss("c26", 1'b1, 64'h2000);
        cyc(); i_rst = 1'b1; #1;  // C27
        chk_skid("c27", 1);
        chk_dec("c27", 1'b1, 64'h2008); chk_iss("c27", 1'b0, 64'h0);
        cyc(); i_rst = 1'b0; i_stall_pc = 1'b0; #1;  // C28
        chk_fetch("c28", 1'b0, 64'h0); chk_dec("c28", 1'b0, 64'h0); chk_iss("c28", 1'b0, 64'h0);
        chk_skid("c28", 0);
        cyc(); #1;  // C29
        chk_fetch("c29", 1'b1, 64'h0);
        cyc(); #1;  // C30
        chk_fetch("c30", 1'b1, 64'h8); chk_dec("c30", 1'b0, 64'h0);
        cyc(); #1;  // C31
        chk_fetch("c31", 1'b1, 64'h10); chk_dec("c31", 1'b1, 64'h0); chk_iss("c31", 1'b0, 64'h0);

        // PC wrap at the top of the address space
        cyc(); i_redirect = 1'b1; i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8; #1;  // C32
        chk_fetch("c32", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8); chk_dec("c32", 1'b1, 64'h8); chk_iss("c32", 1'b1, 64'h0);
        cyc(); i_redirect = 1'b0; #1;  // C33
        chk_fetch("c33", 1'b1, 64'h0); chk_dec("c33", 1'b0, 64'h0); chk_iss("c33", 1'b0, 64'h0);
        cyc(); #1;  // C34
        chk_fetch("c34", 1'b1, 64'h8); chk_dec("c34", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8); chk_iss("c34", 1'b0, 64'h0);
        cyc(); #1;  // C35
        chk_fetch("c35", 1'b1, 64'h10); chk_dec("c35", 1'b1, 64'h0); chk_iss("c35", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc(); #1;  // C36
        chk_fetch("c36", 1'b1, 64'h18); chk_dec("c36", 1'b1, 64'h8); chk_iss("c36", 1'b1, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
